// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and elaboration helpers for sync_fifo_param.
//   clog2()       - constant ceil(log2(n)), used to derive ADDR_W
//   is_pow2()     - power-of-two test for DEPTH
//   cfg_ok()      - full parameter legality check used at elaboration
//   DEF_DATA_W / DEF_DEPTH - default geometry
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int data_w, input int depth,
                                  input int af, input int ae);
        return (data_w >= 1) && (depth >= 2) && is_pow2(depth) &&
               (af >= 0) && (af <= depth) && (ae >= 0) && (ae <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port storage for sync_fifo_param.
// Optional feature macro: SYNC_FIFO_FWFT_EN (combinational read port).
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset (clears the read register only)
//   we/waddr/wdata synchronous write port
//   re/raddr      read port; re loads the read register (standard mode)
//   rdata         read data: registered (standard) or mem[raddr] (FWFT)
// The array itself is never reset.
module sync_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is visible with zero latency; re/rst have no role here.
    assign rdata = mem_q[raddr];

    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst ^ re;
`else
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Sampling mem_q before this edge's write lands gives the old word
    // when a full FIFO reads and writes the same slot.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty flags and one-cycle reject pulses.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through read).
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   wr_en, wr_data      write request and data
//   rd_en               read request (pop / acknowledge in FWFT)
//   rd_data             read data
//   full, empty         count == DEPTH / count == 0
//   almost_full         count >= AF_LEVEL
//   almost_empty        count <= AE_LEVEL
//   count               occupancy 0..DEPTH
//   wr_err, rd_err      registered one-cycle reject pulses
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              wr_err,
    output logic              rd_err
);

    localparam bit CFG_OK = cfg_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL);

    if (!CFG_OK) begin : g_bad_cfg
        $error("sync_fifo_param: DEPTH must be a power of two >= 2 and AF/AE levels <= DEPTH");
    end

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

    // Extra MSB on each pointer is the wrap bit, so wr-rd covers 0..DEPTH.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic            wr_err_q, wr_err_d;
    logic            rd_err_q, rd_err_d;
    logic            wr_acc, rd_acc;

    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A full FIFO still takes a write if a pop frees the slot this edge.
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_err_d = wr_en & ~wr_acc;
        rd_err_d = rd_en & ~rd_acc;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc & ~rst),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_acc & ~rst),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed + random check of sync_fifo_param against a
// queue-based reference model. Works with or without SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF     = DEPTH - 2;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              full, empty, almost_full, almost_empty;
    logic [3:0]        count;
    logic              wr_err, rd_err;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
    );

    // Reference model: contents as a queue plus expected registered outputs.
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] exp_rd;
    logic              exp_werr, exp_rerr;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = model_q.size();
        chk("count",        64'(count),        64'(sz));
        chk("empty",        64'(empty),        64'(sz == 0));
        chk("full",         64'(full),         64'(sz == DEPTH));
        chk("almost_full",  64'(almost_full),  64'(sz >= AF));
        chk("almost_empty", 64'(almost_empty), 64'(sz <= AE));
        chk("wr_err",       64'(wr_err),       64'(exp_werr));
        chk("rd_err",       64'(rd_err),       64'(exp_rerr));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz > 0) chk("rd_data_fwft", 64'(rd_data), 64'(model_q[0]));
`else
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model from
    // the pre-edge occupancy, then compare everything.
    task automatic tick(input logic r, input logic w, input logic [DATA_W-1:0] d,
                        input logic rr);
        int sz;
        rst = r; wr_en = w; wr_data = d; rd_en = rr;
        sz = model_q.size();
        @(posedge clk);
        #1;
        if (r) begin
            model_q.delete();
            exp_rd   = '0;
            exp_werr = 1'b0;
            exp_rerr = 1'b0;
        end else begin
            exp_werr = w && (sz == DEPTH) && !rr;
            exp_rerr = rr && (sz == 0);
            if (rr && sz > 0) exp_rd = model_q.pop_front();
            if (w && (sz < DEPTH || rr)) model_q.push_back(d);
        end
        check_all();
    endtask

    initial begin
        exp_rd = '0; exp_werr = 1'b0; exp_rerr = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

        // Reset then idle
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Fill with 1..8, then an overflowing 9th write
        for (int i = 1; i <= DEPTH; i++) tick(0, 1, DATA_W'(i), 0);
        tick(0, 1, 32'hDEAD, 0);
        tick(0, 0, 0, 0);

        // Drain all 8, then an underflowing 9th read (rd_data holds 8)
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Full with simultaneous read+write: old word out, 0xA5 goes last
        for (int i = 1; i <= DEPTH; i++) tick(0, 1, DATA_W'(8'h40 + i), 0);
        tick(0, 1, 32'hA5, 1);
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 1);

        // Empty with simultaneous read+write: write wins, rd_err pulses
        tick(0, 1, 32'h3C, 1);
        tick(0, 0, 0, 1);

        // Reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) tick(0, 1, DATA_W'(8'h70 + i), 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);

        // FWFT-visible head after a single write, then pop to empty
        tick(0, 1, 32'h11, 0);
        tick(0, 0, 0, 1);

        // Random traffic with alternating fill/drain bias and rare resets
        for (int i = 0; i < 1000; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 70 : 30;
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < wp),
                 $urandom,
                 ($urandom_range(0, 99) < (100 - wp)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
